pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, giving the PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 PcSel  input  1  redirect request from branch resolution; 1 = take BrPC.
REQ-007 BrPC  input  32  redirect target byte address.
REQ-008 Stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-009 imem_req  output  1  one-cycle instruction-memory read strobe.
REQ-010 imem_addr  output  PC_W  byte address of the read; valid only while imem_req=1.
REQ-011 imem_rvalid  input  1  read data valid; arrives 1 or more cycles after imem_req.
REQ-012 imem_rdata  input  32  instruction word returned.
REQ-013 if_valid  output  1  if_pc/if_instr hold a valid fetched instruction.
REQ-014 if_pc  output  PC_W  address of the presented instruction.
REQ-015 if_instr  output  32  presented instruction word.
REQ-016 flush  output  1  combinational copy of PcSel; tells downstream to kill younger stages.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, HOLD, DROP with at most one outstanding memory request.
REQ-018 IDLE: SHALL assert imem_req=1 with imem_addr=pc for exactly one cycle, then move to WAIT.
REQ-019 WAIT without imem_rvalid: SHALL stay in WAIT with imem_req=0.
REQ-020 WAIT with imem_rvalid and Stall=0: SHALL register if_valid=1, if_pc=pc and if_instr=imem_rdata for the next cycle, set pc<=pc+4, and return to IDLE.
REQ-021 WAIT with imem_rvalid and Stall=1: SHALL register the word and move to HOLD.
REQ-022 HOLD: SHALL keep if_valid=1 and keep if_pc/if_instr stable while Stall=1; on Stall=0 it SHALL set pc<=pc+4 and go to IDLE, with if_valid=0 on the following cycle.
REQ-023 Outside WAIT-accept and HOLD, if_valid SHALL be 0 and if_instr SHALL be the NOP word 32'h00000013.
REQ-024 Redirect (PcSel=1) in any state SHALL take priority over Stall and rvalid.
REQ-025 On redirect, pc SHALL load {BrPC[PC_W-1:2],2'b00}, with upper bits truncated and low 2 bits forced to 0.
REQ-026 Redirect in IDLE: the request for that cycle SHALL be suppressed, and the next IDLE cycle SHALL request the new pc.
REQ-027 Redirect in WAIT without rvalid in the same cycle: SHALL move to DROP, which discards the next rvalid and then goes to IDLE.
REQ-028 Redirect in WAIT with rvalid in the same cycle: SHALL discard the data and go to IDLE.
REQ-029 Redirect in HOLD: SHALL clear the held instruction (if_valid=0 next cycle) and go to IDLE.
REQ-030 Redirect in DROP: SHALL update pc and remain in DROP.
REQ-031 pc+4 SHALL wrap modulo 2^PC_W; for PC_W=9, 0x1FC+4 = 0x000.
REQ-032 imem_rvalid while in IDLE or HOLD SHALL be ignored.

Reset
REQ-033 reset=1 SHALL force pc=RESET_PC, state=IDLE, if_valid=0, if_pc=0, if_instr=32'h00000013 and imem_req=0 on the same edge.
REQ-034 Reset during WAIT, HOLD or DROP SHALL abandon the in-flight access, and any rvalid on the cycle after reset SHALL be ignored.
REQ-035 The first imem_req SHALL occur in the first cycle with reset=0.

Structure
REQ-036 A shared package fetch_pkg SHALL hold the state enum, the NOP constant 32'h00000013 and the default PC_W/RESET_PC values.
REQ-037 SHALL be a single module with no sub-modules, because pc next-value logic and FSM are tightly coupled.

Verification
REQ-038 Reset, memory latency 1, Stall=0: SHALL see imem_addr 0x000, 0x004, 0x008 on requests, with if_valid pulses carrying if_pc 0x000, 0x004.
REQ-039 Stall=1 for 3 cycles when the instruction at 0x004 returns: if_valid and if_instr SHALL stay stable 3 cycles, and the next request SHALL be 0x008.
REQ-040 PcSel=1, BrPC=0x0000_0040 while WAIT at 0x010 (latency 3): the late rvalid SHALL be dropped, flush=1 for one cycle, and the next request SHALL be 0x040.
REQ-041 PcSel=1 with BrPC=0x0000_0046 and Stall=1 in HOLD: the held instruction SHALL be cleared, and the next request SHALL be 0x044.
REQ-042 pc=0x1FC, PC_W=9: the next sequential request SHALL be 0x000.
REQ-043 Reset asserted in WAIT, rvalid one cycle later: if_valid SHALL stay 0, and the first request after reset release SHALL be RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: FSM state encoding,
// the NOP instruction word and the default geometry parameters.
package fetch_pkg;

    localparam int          DEFAULT_PC_W     = 9;
    localparam int          DEFAULT_RESET_PC = 0;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // IDLE issues a request, WAIT waits for its data, HOLD keeps a stalled
    // instruction on the outputs, DROP swallows the data of a killed request.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port: one-cycle request strobe with address,
// read data returned later with a valid strobe.
interface pc_fetch_unit_if #(
    parameter int PC_W = fetch_pkg::DEFAULT_PC_W
);

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    // Fetch unit side: issues requests, receives data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side: receives requests, returns data.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: keeps the program counter, issues one instruction-memory
// read at a time and presents the returned word to decode, honouring
// decode back-pressure (Stall) and branch redirects (PcSel/BrPC).
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    pc_fetch_unit_if.master imem,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            flush
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_if_valid;
    logic            w_if_valid_nxt;
    logic [PC_W-1:0] r_if_pc;
    logic [PC_W-1:0] w_if_pc_nxt;
    logic [31:0]     r_if_instr;
    logic [31:0]     w_if_instr_nxt;
    logic            w_req;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_br_target;
    logic            w_unused_brpc;

    // Sequential successor wraps naturally at 2^PC_W.
    assign w_pc_inc    = r_pc + PC_W'(4);
    // Redirect target: truncate to the PC width and force word alignment.
    assign w_br_target = {BrPC[PC_W-1:2], 2'b00};
    // Bits of BrPC that can never reach the PC.
    assign w_unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    // Next-state, next-PC and presented-instruction selection.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = 1'b0;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = NOP_INSTR;
        w_req          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (PcSel) begin
                    // Redirect suppresses this request; the new pc is fetched next cycle.
                    w_pc_nxt = w_br_target;
                end else begin
                    w_req       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (PcSel) begin
                    w_pc_nxt    = w_br_target;
                    // Data arriving now is simply discarded; otherwise it is still in flight.
                    w_state_nxt = imem.imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem.imem_rvalid) begin
                    w_if_valid_nxt = 1'b1;
                    w_if_pc_nxt    = r_pc;
                    w_if_instr_nxt = imem.imem_rdata;
                    if (Stall) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
                if (PcSel) begin
                    w_pc_nxt    = w_br_target;
                    w_state_nxt = ST_IDLE;
                end else if (Stall) begin
                    w_if_valid_nxt = 1'b1;
                    w_if_instr_nxt = r_if_instr;
                end else begin
                    // Decode takes the held word this cycle.
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (PcSel) begin
                    w_pc_nxt = w_br_target;
                end else if (imem.imem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
        end
    end

    // The request strobe is combinational from IDLE, so it is also masked
    // while reset is held to keep the memory quiet during reset.
    assign imem.imem_req  = w_req & ~reset;
    assign imem.imem_addr = r_pc;

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;
    assign flush    = PcSel;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a small latency-programmable memory
// responder plus a linear sequence of steps with hand-computed expectations.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            Stall;
    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            flush;

    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_fail   = 0;
    int              lat      = 1;
    int              pend     = 0;
    logic [PC_W-1:0] pend_addr;
    logic            req_now;
    logic [PC_W-1:0] addr_now;

    always #10 clk = ~clk;

    pc_fetch_unit_if #(.PC_W(PC_W)) imem ();

    pc_fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (9'h000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PcSel    (PcSel),
        .BrPC     (BrPC),
        .Stall    (Stall),
        .imem     (imem),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .flush    (flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply this cycle's control inputs and let combinational outputs settle.
    task automatic drive(input logic psel, input logic [31:0] br, input logic stall, input logic rst);
        PcSel = psel;
        BrPC  = br;
        Stall = stall;
        reset = rst;
        #1;
    endtask

    // Advance one clock; the memory returns 0xC0DE_0000|addr 'lat' cycles after a request.
    task automatic cyc();
        #1;
        req_now  = imem.imem_req;
        addr_now = imem.imem_addr;
        @(posedge clk);
        @(negedge clk);
        if (req_now) begin
            pend      = lat;
            pend_addr = addr_now;
        end
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = 32'hC0DE_0000 | {23'b0, pend_addr};
            end
        end
        #1;
    endtask

    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        pend_addr        = '0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        cyc();
        // Reset held: outputs at reset values, no request.
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", {23'b0, if_pc}, 32'h0);
        check("rst_if_instr", if_instr, NOP_INSTR);
        check("rst_req", {31'b0, imem.imem_req}, 32'h0);

        // First cycle out of reset requests RESET_PC.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("first_req", {31'b0, imem.imem_req}, 32'h1);
        check("first_addr", {23'b0, imem.imem_addr}, 32'h000);
        cyc();
        // WAIT with data returning (latency 1).
        check("wait_req_low", {31'b0, imem.imem_req}, 32'h0);
        check("wait_if_valid", {31'b0, if_valid}, 32'h0);
        cyc();
        check("pulse0_valid", {31'b0, if_valid}, 32'h1);
        check("pulse0_pc", {23'b0, if_pc}, 32'h000);
        check("pulse0_instr", if_instr, 32'hC0DE_0000);
        check("req1_addr", {23'b0, imem.imem_addr}, 32'h004);
        check("req1", {31'b0, imem.imem_req}, 32'h1);
        cyc();
        // Data for 0x004 arrives while decode stalls.
        check("pre_hold_valid", {31'b0, if_valid}, 32'h0);
        check("pre_hold_instr", if_instr, NOP_INSTR);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", {31'b0, if_valid}, 32'h1);
            check("hold_pc", {23'b0, if_pc}, 32'h004);
            check("hold_instr", if_instr, 32'hC0DE_0004);
            check("hold_no_req", {31'b0, imem.imem_req}, 32'h0);
            if (i == 2) drive(1'b0, 32'h0, 1'b0, 1'b0);
            cyc();
        end
        // Stall released: valid drops, next sequential request is 0x008.
        check("post_hold_valid", {31'b0, if_valid}, 32'h0);
        check("post_hold_instr", if_instr, NOP_INSTR);
        check("req2", {31'b0, imem.imem_req}, 32'h1);
        check("req2_addr", {23'b0, imem.imem_addr}, 32'h008);
        cyc();
        cyc();
        check("pulse8_valid", {31'b0, if_valid}, 32'h1);
        check("pulse8_pc", {23'b0, if_pc}, 32'h008);
        check("req3_addr", {23'b0, imem.imem_addr}, 32'h00C);
        cyc();
        cyc();
        // Request 0x010 with latency 3, then redirect while it is in flight.
        check("req4_addr", {23'b0, imem.imem_addr}, 32'h010);
        lat = 3;
        cyc();
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        check("wait_redir_flush", {31'b0, flush}, 32'h1);
        check("wait_redir_req", {31'b0, imem.imem_req}, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("drop_flush_low", {31'b0, flush}, 32'h0);
        check("drop_req", {31'b0, imem.imem_req}, 32'h0);
        cyc();
        // Late data for 0x010 arrives in DROP.
        check("drop_valid", {31'b0, if_valid}, 32'h0);
        check("drop_req2", {31'b0, imem.imem_req}, 32'h0);
        cyc();
        check("after_drop_valid", {31'b0, if_valid}, 32'h0);
        check("after_drop_instr", if_instr, NOP_INSTR);
        check("redir_req", {31'b0, imem.imem_req}, 32'h1);
        check("redir_addr", {23'b0, imem.imem_addr}, 32'h040);
        lat = 1;
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc();
        // Holding 0x040; redirect to 0x46 with Stall still high.
        check("hold40_valid", {31'b0, if_valid}, 32'h1);
        check("hold40_instr", if_instr, 32'hC0DE_0040);
        drive(1'b1, 32'h0000_0046, 1'b1, 1'b0);
        check("hold_redir_flush", {31'b0, flush}, 32'h1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("hold_clr_valid", {31'b0, if_valid}, 32'h0);
        check("hold_clr_instr", if_instr, NOP_INSTR);
        check("req44_addr", {23'b0, imem.imem_addr}, 32'h044);
        cyc();
        cyc();
        check("pulse44_pc", {23'b0, if_pc}, 32'h044);
        // Redirect in IDLE to a truncated, misaligned target -> 0x1FC.
        drive(1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        check("idle_redir_req", {31'b0, imem.imem_req}, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("req1fc", {31'b0, imem.imem_req}, 32'h1);
        check("req1fc_addr", {23'b0, imem.imem_addr}, 32'h1FC);
        cyc();
        cyc();
        check("pulse1fc_pc", {23'b0, if_pc}, 32'h1FC);
        check("pulse1fc_instr", if_instr, 32'hC0DE_01FC);
        check("wrap_addr", {23'b0, imem.imem_addr}, 32'h000);
        cyc();
        // Redirect in WAIT in the same cycle the data arrives.
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("same_cyc_valid", {31'b0, if_valid}, 32'h0);
        check("req100_addr", {23'b0, imem.imem_addr}, 32'h100);
        lat = 2;
        cyc();
        // Reset while in WAIT; the abandoned data lands one cycle after reset.
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("rst_wait_req", {31'b0, imem.imem_req}, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        lat = 1;
        check("post_rst_valid", {31'b0, if_valid}, 32'h0);
        check("post_rst_req", {31'b0, imem.imem_req}, 32'h1);
        check("post_rst_addr", {23'b0, imem.imem_addr}, 32'h000);
        cyc();
        check("stale_ignored", {31'b0, if_valid}, 32'h0);
        cyc();
        check("fresh_valid", {31'b0, if_valid}, 32'h1);
        check("fresh_pc", {23'b0, if_pc}, 32'h000);
        check("fresh_instr", if_instr, 32'hC0DE_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
